// File: rtl/rr_arbiter_x4.sv
// ---------------------------------------------------------------------------
// rr_arbiter_x4
//   Round-robin arbiter that shares one resource among four requesters.
//   Priority rotates after each release: the releasing owner becomes the
//   lowest-priority requester for the search done in the same cycle.
//   Ownership is bounded to MAX_HOLD consecutive cycles so nobody starves.
//   All outputs are registered.
//
// Parameters
//   MAX_HOLD : max consecutive cycles one owner keeps the grant (>= 1)
//   CNT_W    : hold-counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   clk    in   1  rising-edge clock
//   reset  in   1  synchronous, active-high reset
//   req    in   4  request lines, req[i]=1 -> requester i wants the resource
//   grant  out  4  one-hot grant, 4'b0000 when idle
//   gnt_id out  2  binary index of the owner, 0 when idle
//   busy   out  1  high while grant is non-zero
// ---------------------------------------------------------------------------
module rr_arbiter_x4 #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] gnt_id,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  logic [0:0]       state_q,    state_d;
  logic [1:0]       ptr_q,      ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       grant_q,    grant_d;
  logic [1:0]       gnt_id_q,   gnt_id_d;
  logic             busy_q,     busy_d;

  // Working values of the combinational next-state logic.
  logic [2:0] search_s;
  logic [1:0] owner_s;
  logic [1:0] next_ptr_s;
  logic       release_s;

  // Search req starting at index ptr, wrapping 3->0.
  // Result is {found, index}; the smallest offset from ptr wins.
  function automatic logic [2:0] rr_search(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Walk from the farthest offset down so the nearest hit overwrites last.
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state logic for ownership, rotation pointer, hold counter and outputs.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    owner_s    = gnt_id_q;
    next_ptr_s = gnt_id_q + 2'd1;
    release_s  = 1'b0;
    search_s   = 3'b000;

    case (state_q)
      ST_IDLE: begin
        search_s = rr_search(req, ptr_q);
        if (search_s[2]) begin
          state_d    = ST_GRANT;
          grant_d    = 4'b0001 << search_s[1:0];
          gnt_id_d   = search_s[1:0];
          busy_d     = 1'b1;
          hold_cnt_d = HOLD_ONE;
        end else begin
          grant_d    = 4'b0000;
          gnt_id_d   = 2'd0;
          busy_d     = 1'b0;
          hold_cnt_d = {CNT_W{1'b0}};
        end
      end

      ST_GRANT: begin
        release_s = (req[owner_s] == 1'b0) || (hold_cnt_q == HOLD_MAX);
        if (release_s) begin
          // Releasing owner becomes lowest priority for this very search,
          // so a lone requester hitting the hold limit is simply re-granted.
          ptr_d    = next_ptr_s;
          search_s = rr_search(req, next_ptr_s);
          if (search_s[2]) begin
            state_d    = ST_GRANT;
            grant_d    = 4'b0001 << search_s[1:0];
            gnt_id_d   = search_s[1:0];
            busy_d     = 1'b1;
            hold_cnt_d = HOLD_ONE;
          end else begin
            state_d    = ST_IDLE;
            grant_d    = 4'b0000;
            gnt_id_d   = 2'd0;
            busy_d     = 1'b0;
            hold_cnt_d = {CNT_W{1'b0}};
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        ptr_d      = 2'd0;
        hold_cnt_d = {CNT_W{1'b0}};
        grant_d    = 4'b0000;
        gnt_id_d   = 2'd0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      hold_cnt_q <= {CNT_W{1'b0}};
      grant_q    <= 4'b0000;
      gnt_id_q   <= 2'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
    end
  end

  assign grant  = grant_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_rr_arbiter_x4.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_x4
//   Self-checking bench for rr_arbiter_x4 (MAX_HOLD=4). Directed scenarios
//   followed by random request traffic, all compared against a behavioural
//   model that tracks the owner as an integer and rotates priority by
//   modular arithmetic.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_x4;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] gnt_id;
  logic       busy;

  int checks_cnt;
  int fail_cnt;

  // Reference model state: owner -1 means nobody holds the resource.
  int m_owner;
  int m_hold;
  int m_ptr;

  rr_arbiter_x4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .grant  (grant),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First requester found walking p, p+1, p+2, p+3 (mod 4); -1 if none.
  function automatic int first_from(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++) begin
      if (r[(p + off) % 4]) return (p + off) % 4;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_edge(input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      m_owner = -1;
      m_hold  = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      w = first_from(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 1;
      end
    end else if (!r[m_owner] || m_hold == MAX_HOLD) begin
      m_ptr = (m_owner + 1) % 4;
      w     = first_from(r, m_ptr);
      m_owner = w;
      m_hold  = (w >= 0) ? 1 : 0;
    end else begin
      m_hold++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    logic [1:0] ei;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    ei = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    check_eq({tag, "_grant"},  32'(grant),  32'(eg));
    check_eq({tag, "_gnt_id"}, 32'(gnt_id), 32'(ei));
    check_eq({tag, "_busy"},   32'(busy),   32'(m_owner >= 0));
  endtask

  // Apply inputs, clock once, then compare outputs against the model.
  task automatic step(input logic [3:0] r, input logic rs, input string tag);
    req   = r;
    reset = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [3:0] rq;
    checks_cnt = 0;
    fail_cnt   = 0;
    m_owner    = -1;
    m_hold     = 0;
    m_ptr      = 0;
    req        = 4'b0000;
    reset      = 1'b1;

    // T1: reset dominates full requests.
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b1, "t1");
      check_eq("t1_grant_zero", 32'(grant), 32'd0);
    end

    // T2: single requester, then drop.
    step(4'b0100, 1'b0, "t2");
    check_eq("t2_grant_c1", 32'(grant), 32'h4);
    step(4'b0100, 1'b0, "t2");
    check_eq("t2_grant_c2", 32'(grant), 32'h4);
    step(4'b0000, 1'b0, "t2");
    check_eq("t2_idle", 32'(busy), 32'd0);

    // T3: all request, rotation every MAX_HOLD cycles with no gaps.
    step(4'b0000, 1'b1, "t3rst");
    for (int i = 0; i < 20; i++) begin
      step(4'b1111, 1'b0, "t3");
      check_eq("t3_seq", 32'(grant), 32'(4'b0001 << ((i / 4) % 4)));
    end

    // T4: owner 0 drops, passes to 1 without gap, then to 3.
    step(4'b0000, 1'b1, "t4rst");
    step(4'b0001, 1'b0, "t4");
    step(4'b1010, 1'b0, "t4");
    check_eq("t4_pass1", 32'(grant), 32'h2);
    step(4'b1000, 1'b0, "t4");
    check_eq("t4_pass3", 32'(grant), 32'h8);

    // T5: lone requester is re-granted at forced release.
    step(4'b0000, 1'b1, "t5rst");
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, 1'b0, "t5");
      check_eq("t5_hold", 32'({grant, busy}), 32'({4'b0100, 1'b1}));
    end

    // T6: reset mid-hold clears grant and pointer.
    step(4'b1111, 1'b1, "t6");
    check_eq("t6_reset", 32'(grant), 32'd0);
    step(4'b1111, 1'b0, "t6");
    check_eq("t6_restart", 32'(grant), 32'h1);

    // Random traffic, requests mostly sticky, occasional reset.
    rq = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, 3)] = ~rq[$urandom_range(0, 3)];
      step(rq, ($urandom_range(0, 99) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
